// File: rtl/decode_pipe.sv
// decode_pipe: pipelined binary-to-mask decoder with valid/ready handshake.
//
// Decodes an ENC_W-bit index into an OUT_W-bit mask in one of four modes
// (one-hot, thermometer, inverted one-hot, reverse thermometer), flags
// out-of-range indices, and registers the result. A 2-entry store (output
// register + skid register) keeps in_ready registered.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   block can accept a beat (registered)
//   encoded    binary index, ENC_W bits
//   mode       decode mode, sampled with the beat
//   out_valid  decoded beat present (registered)
//   out_ready  downstream accepts the beat
//   decoded    decoded mask, OUT_W bits (registered)
//   oor        index was >= OUT_W, qualified by out_valid (registered)
module decode_pipe #(
    parameter int unsigned ENC_W = 6,
    parameter int unsigned OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ENC_W-1:0] encoded,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] decoded,
    output logic             oor
);

    // One extra bit so OUT_W == 2**ENC_W is representable in the range compare.
    localparam int unsigned CMP_W = ENC_W + 1;

    localparam logic [1:0] MODE_ONEHOT   = 2'b00;
    localparam logic [1:0] MODE_THERM    = 2'b01;
    localparam logic [1:0] MODE_INV_HOT  = 2'b10;
    localparam logic [1:0] MODE_RTHERM   = 2'b11;

    // Elaboration guard on the legal OUT_W range.
    if ((OUT_W < 1) || (64'(OUT_W) > (64'd1 << ENC_W))) begin : g_bad_out_w
        $error("decode_pipe: OUT_W must satisfy 1 <= OUT_W <= 2**ENC_W");
    end

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    state_e             state_q,    state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [OUT_W-1:0]   dec_q,      dec_d;
    logic               oor_q,      oor_d;
    logic [OUT_W-1:0]   skid_dec_q, skid_dec_d;
    logic               skid_oor_q, skid_oor_d;

    logic               in_fire_c;
    logic [OUT_W-1:0]   new_dec_c;
    logic               new_oor_c;

    assign in_fire_c = in_valid & in_ready_q;

    // Input-side decode of the incoming beat.
    always_comb begin
        logic idx_ok;
        new_dec_c = '0;
        idx_ok    = CMP_W'(encoded) < CMP_W'(OUT_W);
        for (int unsigned b = 0; b < OUT_W; b++) begin
            unique case (mode)
                MODE_ONEHOT:  new_dec_c[b] = (ENC_W'(b) == encoded);
                MODE_THERM:   new_dec_c[b] = (ENC_W'(b) <= encoded);
                MODE_INV_HOT: new_dec_c[b] = (ENC_W'(b) != encoded);
                MODE_RTHERM:  new_dec_c[b] = (ENC_W'(b) >= encoded);
                default:      new_dec_c[b] = 1'b0;
            endcase
        end
        // Out-of-range index never yields a partial mask.
        if (!idx_ok) begin
            new_dec_c = '0;
        end
        new_oor_c = ~idx_ok;
    end

    // Occupancy FSM: next state and storage updates.
    always_comb begin
        state_d    = state_q;
        dec_d      = dec_q;
        oor_d      = oor_q;
        skid_dec_d = skid_dec_q;
        skid_oor_d = skid_oor_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire_c) begin
                    state_d = ST_ONE;
                    dec_d   = new_dec_c;
                    oor_d   = new_oor_c;
                end
            end
            ST_ONE: begin
                if (in_fire_c && out_ready) begin
                    // Deliver and reload in the same edge, no bubble.
                    dec_d = new_dec_c;
                    oor_d = new_oor_c;
                end else if (in_fire_c) begin
                    state_d    = ST_FULL;
                    skid_dec_d = new_dec_c;
                    skid_oor_d = new_oor_c;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                    dec_d   = '0;
                    oor_d   = 1'b0;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so no input can arrive.
                if (out_ready) begin
                    state_d    = ST_ONE;
                    dec_d      = skid_dec_q;
                    oor_d      = skid_oor_q;
                    skid_dec_d = '0;
                    skid_oor_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_EMPTY;
                dec_d      = '0;
                oor_d      = 1'b0;
                skid_dec_d = '0;
                skid_oor_d = 1'b0;
            end
        endcase

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            dec_q       <= '0;
            oor_q       <= 1'b0;
            skid_dec_q  <= '0;
            skid_oor_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            dec_q       <= dec_d;
            oor_q       <= oor_d;
            skid_dec_q  <= skid_dec_d;
            skid_oor_q  <= skid_oor_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign decoded   = dec_q;
    assign oor       = oor_q;

endmodule
